// File: rtl/bgr_startup_seq.sv
// bgr_startup_seq
//   Startup and trim sequencer for an array of N_CH bandgap reference cores.
//   The cores are kicked one at a time with porst[ch], then the block waits a
//   settle window and samples the synchronized vbg-alive comparator. A failed
//   start is retried up to MAX_RETRY kicks in total before the block faults.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   level request; low returns the block to IDLE
//   trim_load  in   strobe that captures trim_in (honoured in IDLE only)
//   trim_in    in   N_CH*TRIM_W trim codes, channel k at [k*TRIM_W +: TRIM_W]
//   ok_in      in   N_CH asynchronous vbg-alive comparator outputs
//   porst      out  N_CH kick-start drive, one-hot or zero
//   trim_sel   out  N_CH*TRIM_W registered trim codes
//   ready      out  N_CH channel verified up
//   fault      out  a channel exhausted its retries
//
// Configuration
//   BGR_STARTUP_SEQ_MONITOR_EN : when defined, RUN restarts the whole sequence
//   if any synchronized ok bit stays low for 4 consecutive cycles.
module bgr_startup_seq #(
    parameter int N_CH        = 2,
    parameter int TRIM_W      = 4,
    parameter int STARTUP_CYC = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     trim_load,
    input  logic [N_CH*TRIM_W-1:0]   trim_in,
    input  logic [N_CH-1:0]          ok_in,
    output logic [N_CH-1:0]          porst,
    output logic [N_CH*TRIM_W-1:0]   trim_sel,
    output logic [N_CH-1:0]          ready,
    output logic                     fault
);

    localparam int MAXC = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int RW   = $clog2(MAX_RETRY) + 1;
    localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        SETTLE,
        CHECK,
        RUN,
        FAULT
    } state_t;

    state_t          state, state_n;
    logic [CHW-1:0]  ch, ch_n;
    logic [RW-1:0]   retry, retry_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N_CH-1:0] rdy, rdy_n;
    logic [N_CH-1:0] ok_m, ok_s;
    logic            mon_trip;

    // Two-flop synchronizer for the asynchronous comparator outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_m <= '0;
            ok_s <= '0;
        end else begin
            ok_m <= ok_in;
            ok_s <= ok_m;
        end
    end

`ifdef BGR_STARTUP_SEQ_MONITOR_EN
    logic [2:0] low_cnt;
    logic       any_low;

    assign any_low  = ~&ok_s;
    // Fourth consecutive low sample in RUN trips the restart.
    assign mon_trip = (state == RUN) && any_low && (low_cnt == 3'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_cnt <= '0;
        end else if (en && (state == RUN) && any_low) begin
            if (low_cnt != 3'd3) begin
                low_cnt <= low_cnt + 3'd1;
            end
        end else begin
            low_cnt <= '0;
        end
    end
`else
    assign mon_trip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ch    <= '0;
            retry <= '0;
            cnt   <= '0;
            rdy   <= '0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
            retry <= retry_n;
            cnt   <= cnt_n;
            rdy   <= rdy_n;
        end
    end

    always_comb begin
        state_n = state;
        ch_n    = ch;
        retry_n = retry;
        cnt_n   = cnt;
        rdy_n   = rdy;
        if (!en) begin
            state_n = IDLE;
            ch_n    = '0;
            retry_n = '0;
            cnt_n   = '0;
            rdy_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = KICK;
                    ch_n    = '0;
                    retry_n = '0;
                    cnt_n   = '0;
                end
                KICK: begin
                    if (cnt == CW'(STARTUP_CYC - 1)) begin
                        state_n = SETTLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CW'(SETTLE_CYC - 1)) begin
                        state_n = CHECK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                CHECK: begin
                    cnt_n = '0;
                    if (ok_s[ch]) begin
                        rdy_n[ch] = 1'b1;
                        if (ch == CHW'(N_CH - 1)) begin
                            state_n = RUN;
                        end else begin
                            ch_n    = ch + 1'b1;
                            retry_n = '0;
                            state_n = KICK;
                        end
                    end else begin
                        // retry counts failed kicks; the last allowed one faults.
                        retry_n = retry + 1'b1;
                        if ((retry + 1'b1) < RW'(MAX_RETRY)) begin
                            state_n = KICK;
                        end else begin
                            state_n = FAULT;
                        end
                    end
                end
                RUN: begin
                    if (mon_trip) begin
                        rdy_n   = '0;
                        ch_n    = '0;
                        retry_n = '0;
                        cnt_n   = '0;
                        state_n = KICK;
                    end
                end
                FAULT: begin
                    state_n = FAULT;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the current state, so each pin trails the
    // FSM by one edge; dropping en clears them on the same edge as the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            porst    <= '0;
            ready    <= '0;
            fault    <= 1'b0;
            trim_sel <= '0;
        end else begin
            porst    <= (en && (state == KICK)) ? (N_CH'(1) << ch) : '0;
            ready    <= en ? rdy : '0;
            fault    <= en && (state == FAULT);
            if (trim_load && (state == IDLE)) begin
                trim_sel <= trim_in;
            end
        end
    end

endmodule

// File: tb/tb_bgr_startup_seq.sv
module tb_bgr_startup_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       trim_load;
    logic [7:0] trim_in;
    logic [1:0] ok_in;
    logic [1:0] porst;
    logic [7:0] trim_sel;
    logic [1:0] ready;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;

    bgr_startup_seq #(
        .N_CH(2),
        .TRIM_W(4),
        .STARTUP_CYC(4),
        .SETTLE_CYC(8),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .trim_load(trim_load),
        .trim_in(trim_in),
        .ok_in(ok_in),
        .porst(porst),
        .trim_sel(trim_sel),
        .ready(ready),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rises;
        logic prev;

        rst = 1'b1; en = 1'b0; trim_load = 1'b0; trim_in = 8'h00; ok_in = 2'b11;
        #12;
        check("rst_porst", 32'(porst), 32'h0);
        check("rst_trim", 32'(trim_sel), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        rst = 1'b0;
        tick(); tick();

        // Nominal bring-up; the next edge is edge 0.
        en = 1'b1;
        tick();                              // edge 0
        check("nom_porst_e0", 32'(porst), 32'h0);
        tick();                              // edge 1
        check("nom_porst_e1", 32'(porst), 32'h1);
        repeat (3) tick();                   // edge 4
        check("nom_porst_e4", 32'(porst), 32'h1);
        tick();                              // edge 5
        check("nom_porst_e5", 32'(porst), 32'h0);
        repeat (8) tick();                   // edge 13
        check("nom_ready_e13", 32'(ready), 32'h0);
        tick();                              // edge 14
        check("nom_ready_e14", 32'(ready), 32'h1);
        check("nom_porst_e14", 32'(porst), 32'h2);
        repeat (3) tick();                   // edge 17
        check("nom_porst_e17", 32'(porst), 32'h2);
        tick();                              // edge 18
        check("nom_porst_e18", 32'(porst), 32'h0);
        repeat (8) tick();                   // edge 26
        check("nom_ready_e26", 32'(ready), 32'h1);
        tick();                              // edge 27
        check("nom_ready_e27", 32'(ready), 32'h3);
        check("nom_fault_e27", 32'(fault), 32'h0);
        repeat (3) tick();
        check("nom_run_porst", 32'(porst), 32'h0);

        // ok_in[0] dip of 3 cycles while in RUN: never enough to restart.
        ok_in = 2'b10;
        repeat (3) tick();
        ok_in = 2'b11;
        repeat (6) tick();
        check("mon3_ready", 32'(ready), 32'h3);
        check("mon3_porst", 32'(porst), 32'h0);

        // 4-cycle dip: restarts only with the monitor compiled in.
        ok_in = 2'b10;
        repeat (4) tick();
        ok_in = 2'b11;
        repeat (3) tick();                   // restart edge + 1
`ifdef BGR_STARTUP_SEQ_MONITOR_EN
        check("mon4_ready", 32'(ready), 32'h0);
        check("mon4_porst", 32'(porst), 32'h1);
`else
        check("mon4_ready", 32'(ready), 32'h3);
        check("mon4_porst", 32'(porst), 32'h0);
`endif

        // Channel 0 slow to come up: first CHECK fails, retried.
        en = 1'b0; ok_in = 2'b10;
        repeat (4) tick();
        check("retry_idle_ready", 32'(ready), 32'h0);
        en = 1'b1;
        tick();                              // edge 0
        repeat (12) tick();                  // edge 12
        ok_in = 2'b11;
        tick();                              // edge 13 (CHECK fails)
        check("retry_porst_e13", 32'(porst), 32'h0);
        tick();                              // edge 14
        check("retry_porst_e14", 32'(porst), 32'h1);
        check("retry_ready_e14", 32'(ready), 32'h0);
        repeat (3) tick();                   // edge 17
        check("retry_porst_e17", 32'(porst), 32'h1);
        repeat (9) tick();                   // edge 26
        check("retry_ready_e26", 32'(ready), 32'h0);
        tick();                              // edge 27
        check("retry_ready_e27", 32'(ready), 32'h1);

        // Channel 1 stuck dead: 3 kicks then fault.
        en = 1'b0; ok_in = 2'b01;
        repeat (4) tick();
        en = 1'b1;
        tick();                              // edge 0
        rises = 0;
        prev  = porst[1];
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (porst[1] && !prev) rises++;
            prev = porst[1];
        end
        check("fault_kicks", 32'(rises), 32'd3);
        check("fault_flag", 32'(fault), 32'h1);
        check("fault_ready", 32'(ready), 32'h1);
        check("fault_porst", 32'(porst), 32'h0);
        en = 1'b0;
        tick();
        check("fault_clear", 32'(fault), 32'h0);
        check("fault_ready_clr", 32'(ready), 32'h0);

        // Trim capture in IDLE, ignored outside IDLE, kept across en toggles.
        ok_in = 2'b11;
        tick();
        trim_load = 1'b1; trim_in = 8'hA5;
        tick();
        trim_load = 1'b0;
        check("trim_idle", 32'(trim_sel), 32'hA5);
        en = 1'b1;
        tick();                              // edge 0
        repeat (5) tick();                   // edge 5, SETTLE
        trim_load = 1'b1; trim_in = 8'h3C;
        tick();
        trim_load = 1'b0;
        check("trim_settle", 32'(trim_sel), 32'hA5);

        // Abort mid-SETTLE.
        en = 1'b0;
        tick();
        check("abort_porst", 32'(porst), 32'h0);
        check("abort_ready", 32'(ready), 32'h0);
        check("abort_fault", 32'(fault), 32'h0);
        en = 1'b1;
        tick();
        check("trim_retained", 32'(trim_sel), 32'hA5);
        en = 1'b0;
        tick();

        // trim_load coincident with en rise in IDLE: both take effect.
        trim_load = 1'b1; trim_in = 8'h5A; en = 1'b1;
        tick();                              // edge 0
        trim_load = 1'b0;
        check("trim_with_en", 32'(trim_sel), 32'h5A);
        tick();                              // edge 1
        check("kick_with_trim", 32'(porst), 32'h1);

        // Asynchronous reset mid-KICK.
        #2;
        rst = 1'b1;
        #1;
        check("arst_porst", 32'(porst), 32'h0);
        check("arst_trim", 32'(trim_sel), 32'h0);
        #3;
        rst = 1'b0;
        en  = 1'b0;
        tick();
        check("arst_after_porst", 32'(porst), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
